// File: rtl/stack_if.sv
// Command and result bundle between the control FSM and the operand stack.
// The controller drives commands through master; the stack answers through slave.
interface stack_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   logic                       push;
   logic                       pop;
   logic                       tos;
   logic                       clr;
   logic [WIDTH-1:0]           din;
   logic [WIDTH-1:0]           dout;
   logic                       dout_valid;
   logic [$clog2(DEPTH):0]     count;
   logic                       empty;
   logic                       full;
   logic                       overflow;
   logic                       underflow;

   modport master (
      output push, pop, tos, clr, din,
      input  dout, dout_valid, count, empty, full, overflow, underflow
   );

   modport slave (
      input  push, pop, tos, clr, din,
      output dout, dout_valid, count, empty, full, overflow, underflow
   );
endinterface

// File: rtl/stack_unit.sv
// Operand stack for the stack-based MIPS datapath: push/pop/peek with a
// registered read port, occupancy tracking and sticky overflow/underflow flags.
module stack_unit #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic    clk,
   input  logic    rst,
   stack_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [CNT_W-1:0] sp_q, sp_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic             wr_en;
   logic [PTR_W-1:0] wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [PTR_W-1:0] top_idx;
   logic [WIDTH-1:0] top_word;
   logic             is_empty;
   logic             is_full;
   logic             rd_req;
   logic             pop_ok;

   assign is_empty = (sp_q == '0);
   assign is_full  = (sp_q == CNT_W'(DEPTH));

   // The low pointer bits wrap to 0 when full, so subtracting one still lands on DEPTH-1.
   assign top_idx  = sp_q[PTR_W-1:0] - PTR_W'(1);
   assign top_word = mem_q[top_idx];

   assign rd_req   = bus.pop | bus.tos;
   assign pop_ok   = bus.pop & ~is_empty;

   always_comb begin
      sp_d         = sp_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      overflow_d   = overflow_q;
      underflow_d  = underflow_q;
      wr_en        = 1'b0;
      wr_addr      = sp_q[PTR_W-1:0];
      wr_data      = bus.din;

      if (bus.clr) begin
         sp_d        = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (rd_req) begin
            if (is_empty) begin
               underflow_d = 1'b1;
            end else begin
               dout_d       = top_word;
               dout_valid_d = 1'b1;
            end
         end

         // Pop plus push on a live stack swaps the top in place, so it is legal even when full.
         if (pop_ok && bus.push) begin
            wr_en   = 1'b1;
            wr_addr = top_idx;
         end else if (pop_ok) begin
            sp_d = sp_q - CNT_W'(1);
         end else if (bus.push) begin
            if (is_full) begin
               overflow_d = 1'b1;
            end else begin
               wr_en = 1'b1;
               sp_d  = sp_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp_q         <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         sp_q         <= sp_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   // Storage carries no reset; the write is still blocked while reset is held.
   always_ff @(posedge clk) begin
      if (wr_en && rst) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.count      = sp_q;
   assign bus.empty      = is_empty;
   assign bus.full       = is_full;
   assign bus.overflow   = overflow_q;
   assign bus.underflow  = underflow_q;
endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware operand stack serving the multi-cycle stack-based MIPS datapath. It executes the push, pop and top-of-stack read commands issued by the control FSM, and presents the popped or peeked word on a registered output for the datapath's A/B operand registers. The block tracks its own occupancy, blocks illegal overflow and underflow operations, and records them in sticky error flags for debug.

## Interface
Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of stack entries. Must be a power of two and at least 2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset: asserted when 0.
- push  input  1  write din onto the stack this cycle.
- pop  input  1  remove the top entry and load it into dout.
- tos  input  1  copy the top entry into dout without removing it.
- clr  input  1  synchronous flush: empties the stack and clears the error flags.
- din  input  WIDTH  data to push.
- dout  output  WIDTH  registered result of the last successful pop or tos.
- dout_valid  output  1  one-cycle pulse, high in the cycle after a successful pop or tos.
- count  output  $clog2(DEPTH)+1  number of occupied entries.
- empty  output  1  count == 0 (combinational from count).
- full  output  1  count == DEPTH (combinational from count).
- overflow  output  1  sticky; set by a push rejected because the stack is full.
- underflow  output  1  sticky; set by a pop or tos rejected because the stack is empty.

## Operation
- Storage is a DEPTH x WIDTH register array indexed by sp, where sp equals count.
  - The top entry is mem[sp-1].
  - The array is not reset; after reset, valid data is defined only by count.
- Command priority each cycle:
  - clr overrides everything else.
  - pop and tos are mutually overriding: when both are asserted, pop wins.
  - push combines with pop or tos as described below.
- push alone:
  - If not full: mem[sp] <= din and sp <= sp+1.
  - If full: nothing is written, sp is unchanged, and overflow is set to 1.
- pop alone:
  - If not empty: dout <= mem[sp-1], sp <= sp-1, dout_valid is high next cycle.
  - If empty: dout holds its value, dout_valid stays 0, and underflow is set to 1.
- tos alone:
  - If not empty: dout <= mem[sp-1], sp is unchanged, dout_valid is high next cycle.
  - If empty: treated the same as a rejected pop.
- push together with pop, not empty:
  - dout <= old top and mem[sp-1] <= din (replace top).
  - count is unchanged and dout_valid is high next cycle.
  - This is legal even when full; overflow is not set.
- push together with pop, empty:
  - The pop is rejected and underflow is set.
  - The push proceeds (mem[0] <= din, count becomes 1).
- push together with tos:
  - dout <= old top (when not empty) and the push proceeds under the normal push rules.
  - A full stack therefore still sets overflow.
- clr:
  - sp <= 0, overflow <= 0, underflow <= 0, dout_valid <= 0.
  - dout holds its value.
- No command asserted: the block holds all state, and dout_valid goes to 0.

## Timing
- Reset (rst=0) immediately forces: count=0, empty=1, full=0, dout=0, dout_valid=0, overflow=0, underflow=0.
- Reset asserted mid-operation aborts any command sampled on the same edge. Reset release is synchronized by the user.
- Read latency is one cycle: a pop or tos sampled at edge N makes dout and dout_valid valid after edge N, so they are usable by a register load at edge N+1.
- Push latency is one cycle: a word pushed at edge N is returned by a tos or pop sampled at edge N+1.
- Consecutive pops, one per cycle, are supported with no bubble.
- count, empty and full reflect post-edge state, with no combinational path from the command inputs.
- There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use WIDTH=8, DEPTH=4.
- Reset: drive rst=0 with push=1 and din=8'hFF held -> count=0, dout=8'h00, empty=1, all flags 0. After release, one push -> count=1.
- Ordering: push 8'h11, 8'h22, 8'h33, then pop three times back-to-back -> dout=8'h33, 8'h22, 8'h11 on successive cycles, dout_valid high for 3 cycles, empty=1 at the end.
- Overflow: push 8'hA0..8'hA4 (five pushes) -> full=1 after the 4th push, the 5th push sets overflow=1 and count stays 4, subsequent pops return A3, A2, A1, A0.
- Underflow and tos: tos on an empty stack -> underflow=1, dout_valid=0. Then push 8'h5A and tos -> dout=8'h5A with count=1. Then clr -> underflow=0, count=0.
- Replace top: push 8'h01, 8'h02, then push 8'h7F with pop in the same cycle -> dout=8'h02 and count=2; a following pop returns 8'h7F.
- Controller sequence: push 8'h03, push 8'h05; pop (dout=8'h05); pop (dout=8'h03); push 8'h08 -> count=1 and tos returns 8'h08.
